// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: turns one RV32I load/store into one AXI-lite transaction,
// placing store byte lanes and sign/zero-extending load lanes into a single-cycle response.
module lsu_axi_master #(
  parameter int AXI_AWIDTH = 10,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [AXI_AWIDTH-1:0] AXI_AWADDR,
  output logic                  AXI_AWVALID,
  input  logic                  AXI_AWREADY,
  output logic [AXI_DWIDTH-1:0] AXI_WDATA,
  output logic [3:0]            AXI_WSTRB,
  output logic                  AXI_WVALID,
  input  logic                  AXI_WREADY,
  input  logic [1:0]            AXI_BRESP,
  input  logic                  AXI_BVALID,
  output logic                  AXI_BREADY,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
  logic                    berr_q, berr_d;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic                    rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AXI_AWIDTH+2];

  function automatic logic bad_req(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic illegal, misaligned;
    illegal    = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    misaligned = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    return illegal || misaligned;
  endfunction

  // Returns {wstrb, wdata}; data is replicated so the slave picks the lane via the strobe.
  function automatic logic [35:0] store_lanes(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4'b0001 << off, {4{wd[7:0]}}};
      2'b01:   return {(off[1] ? 4'b1100 : 4'b0011), {2{wd[15:0]}}};
      default: return {4'b1111, wd};
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> {off, 3'b000};
    case (f3)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'd0, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd5:    return {16'd0, s[15:0]};
      default: return s;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    b_done_d    = b_done_q;
    berr_d      = berr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'd0;
    accept      = req_valid & req_ready_q;
    aw_hs       = awvalid_q & AXI_AWREADY;
    w_hs        = wvalid_q & AXI_WREADY;
    b_hs        = bready_q & AXI_BVALID;
    ar_hs       = arvalid_q & AXI_ARREADY;
    r_hs        = rready_q & AXI_RVALID;

    case (state_q)
      IDLE: if (accept) begin
        addr_d   = req_addr[AXI_AWIDTH+1:2];
        funct3_d = req_funct3;
        off_d    = req_addr[1:0];
        if (bad_req(req_we, req_funct3, req_addr[1:0])) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (req_we) begin
          {wstrb_d, wdata_d} = store_lanes(req_funct3, req_addr[1:0], req_wdata);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          b_done_d  = 1'b0;
          berr_d    = 1'b0;
          state_d   = WRITE;
        end else begin
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          state_d   = RADDR;
        end
      end
      WRITE: begin
        awvalid_d = awvalid_q & ~AXI_AWREADY;
        wvalid_d  = wvalid_q & ~AXI_WREADY;
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (b_hs) begin
          bready_d = 1'b0;
          b_done_d = 1'b1;
          berr_d   = (AXI_BRESP != 2'b00);
        end
        if (aw_done_d && w_done_d) begin
          if (b_done_d) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = berr_d;
          end else begin
            state_d = WRESP;
          end
        end
      end
      WRESP: if (b_hs) begin
        bready_d    = 1'b0;
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = (AXI_BRESP != 2'b00);
      end
      RADDR: begin
        arvalid_d = arvalid_q & ~AXI_ARREADY;
        if (ar_hs) state_d = RDATA;
      end
      RDATA: ;
      default: state_d = IDLE;
    endcase

    // Read data may arrive in the AR cycle (RADDR) or later (RDATA); both finish here.
    if ((state_q == RADDR && ar_hs && r_hs) || (state_q == RDATA && r_hs)) begin
      rready_d    = 1'b0;
      state_d     = RESP;
      rsp_valid_d = 1'b1;
      if (AXI_RRESP != 2'b00) rsp_err_d = 1'b1;
      else rsp_rdata_d = load_extract(funct3_q, off_q, AXI_RDATA);
    end

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      berr_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      b_done_q    <= b_done_d;
      berr_q      <= berr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign AXI_AWADDR  = addr_q;
  assign AXI_ARADDR  = addr_q;
  assign AXI_AWVALID = awvalid_q;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WSTRB   = wstrb_q;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master with a small AXI-lite RAM slave (configurable ready, B delay, error responses).
module tb_lsu_axi_master;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [9:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  lsu_axi_master #(.AXI_AWIDTH(10), .AXI_DWIDTH(32)) dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave configuration, driven only from the main sequence.
  int          bdelay;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic        awready_cfg, wready_cfg;
  assign awready = awready_cfg;
  assign wready  = wready_cfg;
  assign arready = 1'b1;

  logic [31:0] ram [0:63];
  logic        bpend;
  int          bcnt;

  always @(posedge clk) begin
    if (rst) begin
      bvalid <= 1'b0;
      bpend  <= 1'b0;
      rvalid <= 1'b0;
      bresp  <= 2'b00;
      rresp  <= 2'b00;
      rdata  <= 32'd0;
      bcnt   <= 0;
    end else begin
      if (awvalid && awready && wvalid && wready) begin
        for (int i = 0; i < 4; i++)
          if (wstrb[i]) ram[awaddr[5:0]][8*i +: 8] <= wdata[8*i +: 8];
        bresp <= bresp_cfg;
        if (bdelay == 0) bvalid <= 1'b1;
        else begin
          bpend <= 1'b1;
          bcnt  <= bdelay - 1;
        end
      end
      if (bpend) begin
        if (bcnt == 0) begin
          bvalid <= 1'b1;
          bpend  <= 1'b0;
        end else bcnt <= bcnt - 1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= ram[araddr[5:0]];
        rresp  <= rresp_cfg;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int          cyc, aw_cnt, w_cnt, ar_cnt, rsp_cnt, overlap_cnt, b_cyc;
  logic [9:0]  cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (awvalid) begin
      aw_cnt     <= aw_cnt + 1;
      cap_awaddr <= awaddr;
    end
    if (wvalid) begin
      w_cnt     <= w_cnt + 1;
      cap_wdata <= wdata;
      cap_wstrb <= wstrb;
    end
    if (arvalid) begin
      ar_cnt     <= ar_cnt + 1;
      cap_araddr <= araddr;
    end
    if (awvalid && arvalid) overlap_cnt <= overlap_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (bvalid && bready) b_cyc <= cyc;
  end

  int          errors, checks;
  logic [31:0] r_rdata;
  logic        r_err;
  int          lat, ready_seen, rsp_cyc;
  int          aw0, w0, ar0, rsp0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0BAD_0BAD;
    lat = 1;
    ready_seen = 0;
    while (!rsp_valid && lat < 50) begin
      if (req_ready) ready_seen++;
      @(posedge clk); #1; lat++;
    end
    check("rsp_seen", rsp_valid, 1);
    r_rdata = rsp_rdata;
    r_err   = rsp_err;
    rsp_cyc = cyc;
    @(posedge clk); #1;
    check("one_pulse_then_ready", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0;
    cyc = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0; rsp_cnt = 0; overlap_cnt = 0; b_cyc = 0;
    bdelay = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00; awready_cfg = 1'b1; wready_cfg = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("reset_outputs",
          {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err, rsp_rdata != 0,
           awaddr != 0, araddr != 0, wdata != 0, wstrb != 0}, 0);
    check("reset_ready", req_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store and readback
    aw0 = aw_cnt; w0 = w_cnt;
    issue(1'b1, 3'd2, 32'h10, 32'hCAFE_BABE);
    check("sw_awaddr", cap_awaddr, 4);
    check("sw_wstrb", cap_wstrb, 4'b1111);
    check("sw_wdata", cap_wdata, 32'hCAFE_BABE);
    check("sw_err_rdata", {r_err, r_rdata}, 0);
    check("sw_latency", lat, 3);
    check("sw_aw_w_one_cycle", {aw_cnt - aw0, w_cnt - w0}, {32'd1, 32'd1});
    issue(1'b0, 3'd2, 32'h10, 32'd0);
    check("lw_araddr", cap_araddr, 4);
    check("lw_data", r_rdata, 32'hCAFE_BABE);
    check("lw_latency", lat, 3);

    // Byte store, signed and unsigned byte loads
    issue(1'b1, 3'd0, 32'h13, 32'h0000_00A5);
    check("sb_wstrb", cap_wstrb, 4'b1000);
    check("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    issue(1'b0, 3'd0, 32'h13, 32'd0);
    check("lb_data", r_rdata, 32'hFFFF_FFA5);
    issue(1'b0, 3'd4, 32'h13, 32'd0);
    check("lbu_data", r_rdata, 32'h0000_00A5);
    issue(1'b0, 3'd4, 32'h11, 32'd0);
    check("lbu_off1", r_rdata, 32'h0000_00BA);

    // Half-word store in the upper half, half/word loads
    issue(1'b1, 3'd1, 32'h22, 32'h0000_8001);
    check("sh_wstrb", cap_wstrb, 4'b1100);
    check("sh_wdata", cap_wdata, 32'h8001_8001);
    issue(1'b0, 3'd1, 32'h22, 32'd0);
    check("lh_data", r_rdata, 32'hFFFF_8001);
    issue(1'b0, 3'd5, 32'h22, 32'd0);
    check("lhu_data", r_rdata, 32'h0000_8001);
    issue(1'b0, 3'd2, 32'h20, 32'd0);
    check("lw_upper_half", r_rdata >> 16, 32'h0000_8001);

    // Misaligned and illegal requests never reach the bus
    issue(1'b1, 3'd2, 32'h04, 32'h1122_3344);
    aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
    issue(1'b0, 3'd2, 32'h06, 32'd0);
    check("lw_misaligned", {r_err, r_rdata != 0}, 2'b10);
    check("lw_misaligned_lat", lat, 1);
    issue(1'b1, 3'd1, 32'h05, 32'h0000_BEEF);
    check("sh_misaligned", r_err, 1);
    check("sh_misaligned_lat", lat, 1);
    issue(1'b0, 3'd3, 32'h04, 32'd0);
    check("load_f3_illegal", r_err, 1);
    issue(1'b1, 3'd5, 32'h04, 32'h0000_BEEF);
    check("store_f3_illegal", r_err, 1);
    check("no_bus_activity", {aw_cnt - aw0, w_cnt - w0, ar_cnt - ar0}, 0);
    issue(1'b0, 3'd2, 32'h04, 32'd0);
    check("ram_unchanged", r_rdata, 32'h1122_3344);

    // Slave error responses
    rresp_cfg = 2'b10;
    issue(1'b0, 3'd2, 32'h10, 32'd0);
    check("rresp_err", {r_err, r_rdata != 0}, 2'b10);
    rresp_cfg = 2'b00;
    bresp_cfg = 2'b10;
    issue(1'b1, 3'd2, 32'h30, 32'h0000_0005);
    check("bresp_err", r_err, 1);
    bresp_cfg = 2'b00;

    // Slow write response
    bdelay = 5;
    issue(1'b1, 3'd2, 32'h30, 32'h0000_0007);
    check("bdelay_latency", lat, 8);
    check("bdelay_ready_low", ready_seen, 0);
    check("bdelay_rsp_after_b", rsp_cyc - b_cyc, 1);
    check("bdelay_err", r_err, 0);
    bdelay = 0;

    // Reset in the middle of a write
    awready_cfg = 1'b0; wready_cfg = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_in_write", {awvalid, wvalid}, 2'b11);
    rsp0 = rsp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valids_low", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("abort_idle", req_ready, 1);
    rst = 1'b0; awready_cfg = 1'b1; wready_cfg = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("abort_no_rsp", rsp_cnt - rsp0, 0);
    issue(1'b1, 3'd2, 32'h40, 32'h1234_5678);
    check("post_abort_sw_err", r_err, 0);
    issue(1'b0, 3'd2, 32'h40, 32'd0);
    check("post_abort_lw", r_rdata, 32'h1234_5678);

    check("no_aw_ar_overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
